alarm_controller: RTL and testbench

- Downstream consumer of the 12-hour BCD timekeeping counter (`pm`, `hh`, `mm`, `ss`) and of the same one-second `ena` tick that advances it.
- Holds a programmable alarm time and a disarmed/armed/ringing/snoozed state machine.
- Drives the ring output and the user-facing status outputs.
- All time values are packed BCD, tens nibble in [7:4] and units nibble in [3:0], with the same encoding as the timekeeper.

---
 rtl/alarm_controller.sv | 209 ++++++++++++++++++++
 tb/tb_alarm_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// alarm_controller
//   Alarm logic that sits downstream of the 12-hour BCD timekeeper. It holds a
//   programmable alarm time and runs a disarmed/armed/ringing/snoozed state
//   machine. It advances on the same one-second `ena` tick as the timekeeper.
//   All time values are packed BCD (tens in [7:4], units in [3:0]).
//
// Parameters
//   RING_SECS    ena ticks the alarm rings before it stops by itself
//   SNOOZE_SECS  ena ticks spent snoozing before ringing again
//   MAX_SNOOZE   snoozes allowed per alarm event (1..3)
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   ena                 one-second tick
//   pm, hh, mm, ss      current time from the timekeeper
//   set_valid/set_ready alarm-time write handshake; set_pm/set_hh/set_mm carry the data
//   arm, disarm,        single-cycle user requests
//   snooze, dismiss
//   armed               high in ARMED, RINGING and SNOOZED
//   alarm_on            high in RINGING only
//   snooze_cnt          snoozes used in the current event
//   set_err             one-cycle pulse on a rejected write
//
// Build option
//   ALARM_BCD_CHECK_EN  when defined, a write is stored only if set_hh is
//                       01..12 and set_mm is 00..59 in BCD. Otherwise the write
//                       completes its handshake, is discarded, and set_err pulses.
//                       When undefined, every write is stored and set_err is 0.

module alarm_controller #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       pm,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic       set_pm,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic       arm,
  input  logic       disarm,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       armed,
  output logic       alarm_on,
  output logic [1:0] snooze_cnt,
  output logic       set_err
);

  localparam int RW = $clog2(RING_SECS) + 1;
  localparam int SW = $clog2(SNOOZE_SECS) + 1;

  localparam logic [RW-1:0] RING_LOAD    = RW'(RING_SECS);
  localparam logic [SW-1:0] SNOOZE_LOAD  = SW'(SNOOZE_SECS);
  localparam logic [RW-1:0] RING_ONE     = RW'(1);
  localparam logic [SW-1:0] SNOOZE_ONE   = SW'(1);
  localparam logic [1:0]    SNOOZE_LIMIT = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RINGING,
    SNOOZED
  } state_t;

  state_t        state;
  logic          al_pm;
  logic [7:0]    al_hh;
  logic [7:0]    al_mm;
  logic [RW-1:0] ring_t;
  logic [SW-1:0] snz_t;
  logic [1:0]    snz_cnt;

  logic xfer;
  logic match;
  logic write_ok;

  // Writes are only taken while no alarm event is in progress.
  assign set_ready = ~reset & ((state == IDLE) | (state == ARMED));
  assign xfer      = set_valid & set_ready;

  // ss == 00 together with ena makes this fire once per alarm minute.
  assign match = (state == ARMED) & ena & (pm == al_pm) & (hh == al_hh) &
                 (mm == al_mm) & (ss == 8'h00);

  assign armed      = (state != IDLE);
  assign alarm_on   = (state == RINGING);
  assign snooze_cnt = snz_cnt;

`ifdef ALARM_BCD_CHECK_EN
  logic hh_ok;
  logic mm_ok;
  logic err_q;

  always_comb begin
    hh_ok = 1'b0;
    mm_ok = 1'b0;
    if (set_hh[7:4] == 4'd0)
      hh_ok = (set_hh[3:0] >= 4'd1) && (set_hh[3:0] <= 4'd9);
    else if (set_hh[7:4] == 4'd1)
      hh_ok = (set_hh[3:0] <= 4'd2);
    mm_ok = (set_mm[7:4] <= 4'd5) && (set_mm[3:0] <= 4'd9);
  end

  assign write_ok = hh_ok & mm_ok;

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= xfer & ~write_ok;
  end

  assign set_err = err_q;
`else
  assign write_ok = 1'b1;
  assign set_err  = 1'b0;
`endif

  // Alarm time registers; a transfer never affects the state machine.
  always_ff @(posedge clk) begin
    if (reset) begin
      al_pm <= 1'b0;
      al_hh <= 8'h12;
      al_mm <= 8'h00;
    end else if (xfer && write_ok) begin
      al_pm <= set_pm;
      al_hh <= set_hh;
      al_mm <= set_mm;
    end
  end

  // Priority: disarm > dismiss > snooze > timer expiry / match > arm.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ring_t  <= '0;
      snz_t   <= '0;
      snz_cnt <= '0;
    end else if (disarm) begin
      state   <= IDLE;
      ring_t  <= '0;
      snz_t   <= '0;
      snz_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) state <= ARMED;
        end

        ARMED: begin
          if (match) begin
            state   <= RINGING;
            ring_t  <= RING_LOAD;
            snz_cnt <= '0;
          end
        end

        RINGING: begin
          if (dismiss) begin
            state   <= ARMED;
            ring_t  <= '0;
            snz_t   <= '0;
            snz_cnt <= '0;
          end else if (snooze && (snz_cnt < SNOOZE_LIMIT)) begin
            state   <= SNOOZED;
            snz_cnt <= snz_cnt + 2'd1;
            snz_t   <= SNOOZE_LOAD;
            ring_t  <= '0;
          end else if (ena) begin
            // A snooze beyond the limit falls through to here: ringing goes on.
            if (ring_t == RING_ONE) begin
              state   <= ARMED;
              ring_t  <= '0;
              snz_cnt <= '0;
            end else begin
              ring_t <= ring_t - RING_ONE;
            end
          end
        end

        SNOOZED: begin
          if (dismiss) begin
            state   <= ARMED;
            ring_t  <= '0;
            snz_t   <= '0;
            snz_cnt <= '0;
          end else if (ena) begin
            if (snz_t == SNOOZE_ONE) begin
              state  <= RINGING;
              ring_t <= RING_LOAD;
              snz_t  <= '0;
            end else begin
              snz_t <= snz_t - SNOOZE_ONE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Testbench for alarm_controller: directed scenarios followed by randomized
// traffic. Expected outputs are queued by the stimulus side from a reference
// model and checked by an independent monitor after each rising edge.
module tb_alarm_controller;

  localparam int RING   = 4;
  localparam int SNZ    = 3;
  localparam int MAXSNZ = 2;

  logic       clk = 1'b0;
  logic       reset, ena, pm;
  logic [7:0] hh, mm, ss;
  logic       set_valid, set_ready, set_pm;
  logic [7:0] set_hh, set_mm;
  logic       arm, disarm, snooze, dismiss;
  logic       armed, alarm_on, set_err;
  logic [1:0] snooze_cnt;

  alarm_controller #(
    .RING_SECS  (RING),
    .SNOOZE_SECS(SNZ),
    .MAX_SNOOZE (MAXSNZ)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ena       (ena),
    .pm        (pm),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .set_valid (set_valid),
    .set_ready (set_ready),
    .set_pm    (set_pm),
    .set_hh    (set_hh),
    .set_mm    (set_mm),
    .arm       (arm),
    .disarm    (disarm),
    .snooze    (snooze),
    .dismiss   (dismiss),
    .armed     (armed),
    .alarm_on  (alarm_on),
    .snooze_cnt(snooze_cnt),
    .set_err   (set_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Expected {armed, alarm_on, set_ready, snooze_cnt[1:0], set_err}
  logic [5:0] exp_q[$];
  string      tag_q[$];

  // Reference model: user-visible situation of the alarm.
  bit          m_on;        // alarm enabled (not idle)
  bit          m_ring;      // currently ringing
  bit          m_snz;       // currently snoozing
  int          ring_left;
  int          snz_left;
  int          snz_used;
  logic [16:0] m_key;       // stored alarm {pm, hh, mm}

`ifdef ALARM_BCD_CHECK_EN
  function automatic bit legal(input logic [7:0] h, input logic [7:0] m);
    int hv, mt, mu;
    hv = 10 * int'(h[7:4]) + int'(h[3:0]);
    mt = int'(m[7:4]);
    mu = int'(m[3:0]);
    return (h[3:0] <= 4'd9) && (hv >= 1) && (hv <= 12) && (mt <= 5) && (mu <= 9);
  endfunction
`endif

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_and_push(input string tag);
    logic        err;
    logic [16:0] new_key;
    bit          ready_now, xfer, hit;
    err       = 1'b0;
    new_key   = m_key;
    ready_now = !reset && !m_ring && !m_snz;
    if (reset) begin
      m_on = 0; m_ring = 0; m_snz = 0;
      ring_left = 0; snz_left = 0; snz_used = 0;
      m_key = {1'b0, 8'h12, 8'h00};
    end else begin
      xfer = set_valid && ready_now;
      if (xfer) begin
`ifdef ALARM_BCD_CHECK_EN
        if (legal(set_hh, set_mm)) new_key = {set_pm, set_hh, set_mm};
        else err = 1'b1;
`else
        new_key = {set_pm, set_hh, set_mm};
`endif
      end
      hit = m_on && !m_ring && !m_snz && ena && ({pm, hh, mm} == m_key) && (ss == 8'h00);
      if (disarm) begin
        m_on = 0; m_ring = 0; m_snz = 0;
        ring_left = 0; snz_left = 0; snz_used = 0;
      end else if (dismiss && (m_ring || m_snz)) begin
        m_ring = 0; m_snz = 0; snz_used = 0;
      end else if (snooze && m_ring && snz_used < MAXSNZ) begin
        m_ring = 0; m_snz = 1; snz_used++; snz_left = SNZ;
      end else if (m_ring && ena) begin
        ring_left--;
        if (ring_left == 0) begin m_ring = 0; snz_used = 0; end
      end else if (m_snz && ena) begin
        snz_left--;
        if (snz_left == 0) begin m_snz = 0; m_ring = 1; ring_left = RING; end
      end else if (hit) begin
        m_ring = 1; ring_left = RING; snz_used = 0;
      end else if (!m_on && arm) begin
        m_on = 1;
      end
      m_key = new_key;
    end
    exp_q.push_back({m_on, m_ring, (!reset && !m_ring && !m_snz), 2'(snz_used), err});
    tag_q.push_back(tag);
  endtask

  task automatic clr_pulses();
    ena = 0; arm = 0; disarm = 0; snooze = 0; dismiss = 0;
  endtask

  task automatic tm(input logic p, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    pm = p; hh = h; mm = m; ss = s;
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic step(input string tag);
    model_and_push(tag);
    @(negedge clk);
    clr_pulses();
  endtask

  // Monitor: compares the DUT against the oldest queued expectation.
  initial begin
    logic [5:0] got, e;
    string      t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        got = {armed, alarm_on, set_ready, snooze_cnt, set_err};
        tests++;
        if (got !== e) begin
          fails++;
          $display("FAIL %s: got armed=%b alarm_on=%b set_ready=%b snooze_cnt=%0d set_err=%b, expected armed=%b alarm_on=%b set_ready=%b snooze_cnt=%0d set_err=%b",
                   t, got[5], got[4], got[3], got[2:1], got[0], e[5], e[4], e[3], e[2:1], e[0]);
        end
      end
    end
  end

  initial begin
    int waitc;
    reset = 1; set_valid = 0; set_pm = 0; set_hh = 8'h12; set_mm = 8'h00;
    clr_pulses();
    tm(0, 8'h11, 8'h59, 8'h59);
    @(negedge clk);

    reset = 1; repeat (3) step("in_reset");
    reset = 0; step("idle_after_reset");

    // Reset alarm time is 12:00 AM
    arm = 1; ena = 1; step("arm_from_idle");
    tm(0, 8'h12, 8'h00, 8'h00); ena = 1; step("reset_alarm_1200am");
    dismiss = 1; step("dismiss_ringing");

    // Normal alarm at 07:30 AM and false-match checks
    set_valid = 1; set_pm = 0; set_hh = 8'h07; set_mm = 8'h30; step("write_0730am");
    set_valid = 0;
    tm(1, 8'h07, 8'h30, 8'h00); ena = 1; step("pm_no_match");
    tm(0, 8'h07, 8'h30, 8'h01); ena = 1; step("ss01_no_match");
    tm(0, 8'h07, 8'h30, 8'h00); step("no_ena_no_match");
    step("no_ena_hold");
    ena = 1; step("match_0730am");
    repeat (3) begin ena = 1; step("ring_tick"); step("ring_gap"); end
    ena = 1; step("ring_auto_stop");
    step("armed_after_stop");

    // Snooze limit
    ena = 1; step("rematch_0730am");
    snooze = 1; step("snooze_1");
    repeat (2) begin ena = 1; step("snooze_tick"); end
    ena = 1; step("snooze_expire");
    snooze = 1; step("snooze_2");
    repeat (3) begin ena = 1; step("snooze2_tick"); end
    snooze = 1; step("snooze_3_ignored");
    step("still_ringing");

    // Write stalls while ringing, completes one cycle after dismiss
    set_valid = 1; set_pm = 1; set_hh = 8'h08; set_mm = 8'h15;
    repeat (2) step("write_stalled");
    dismiss = 1; step("dismiss_with_pending_write");
    step("stalled_write_accepted");
    set_valid = 0;
    tm(1, 8'h08, 8'h15, 8'h00); ena = 1; step("match_0815pm");
    snooze = 1; step("snooze_before_dismiss");
    dismiss = 1; step("dismiss_snoozed");
    ena = 1; step("rematch_0815pm");
    disarm = 1; snooze = 1; step("disarm_beats_snooze");

    // Arm together with a write
    arm = 1; set_valid = 1; set_pm = 0; set_hh = 8'h06; set_mm = 8'h45; step("arm_and_write");
    set_valid = 0;
    tm(0, 8'h06, 8'h45, 8'h00); ena = 1; step("match_0645am");
    disarm = 1; step("disarm_ringing");

`ifdef ALARM_BCD_CHECK_EN
    set_valid = 1; set_pm = 0; set_hh = 8'h13; set_mm = 8'h00; step("bad_hour_13");
    set_valid = 0; step("set_err_one_cycle");
    set_valid = 1; set_hh = 8'h05; set_mm = 8'h60; step("bad_minute_60");
    set_valid = 1; set_hh = 8'h00; set_mm = 8'h10; step("bad_hour_00");
    set_valid = 0;
    arm = 1; step("arm_after_bad_writes");
    tm(0, 8'h06, 8'h45, 8'h00); ena = 1; step("old_alarm_kept");
    disarm = 1; step("disarm_after_check");
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 399) == 0);
      ena     = ($urandom_range(0, 2) == 0);
      arm     = ($urandom_range(0, 7) == 0);
      disarm  = ($urandom_range(0, 59) == 0);
      snooze  = ($urandom_range(0, 5) == 0);
      dismiss = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) begin
        set_valid = 1;
        set_pm    = 1'($urandom_range(0, 1));
        set_hh    = to_bcd($urandom_range(1, 12));
        set_mm    = to_bcd($urandom_range(0, 59));
`ifdef ALARM_BCD_CHECK_EN
        if ($urandom_range(0, 5) == 0) set_hh = 8'h13;
`endif
      end else begin
        set_valid = 0;
      end
      if ($urandom_range(0, 2) == 0) {pm, hh, mm} = m_key;
      else tm(1'($urandom_range(0, 1)), to_bcd($urandom_range(1, 12)),
              to_bcd($urandom_range(0, 59)), 8'h00);
      ss = ($urandom_range(0, 1) == 0) ? 8'h00 : to_bcd($urandom_range(1, 59));
      step("random");
    end
    reset = 0; set_valid = 0;

    waitc = 0;
    while (exp_q.size() > 0 && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
